// File: rtl/mem_pkg.sv
// Shared types for the multiport delay memory.
package mem_pkg;

    typedef enum logic [1:0] {
        RDW_OLD_DATA,
        RDW_NEW_DATA,
        RDW_INVALID
    } rdw_mode_e;

endpackage

// File: rtl/delay_pipe.sv
// Fixed-latency valid/payload shift line; payload is forced to zero in invalid slots.
module delay_pipe #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_payload,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_payload
);

    if (DEPTH < 1) begin : g_bad_depth
        $error("delay_pipe: DEPTH must be at least 1");
    end

    logic [DEPTH-1:0] vld;
    logic [WIDTH-1:0] pay [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            vld <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pay[i] <= '0;
            end
        end else begin
            vld[0] <= in_valid;
            pay[0] <= in_valid ? in_payload : '0;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                vld[i] <= vld[i-1];
                pay[i] <= pay[i-1];
            end
        end
    end

    assign out_valid   = vld[DEPTH-1];
    assign out_payload = pay[DEPTH-1];

endmodule

// File: rtl/multiport_delay_mem.sv
// Flip-flop memory with one write port and NUM_RD_PORTS fixed-latency read ports.
module multiport_delay_mem
    import mem_pkg::*;
#(
    parameter int unsigned MEM_DEPTH    = 8,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int          DELAY_CYCLES = 3,
    parameter int          NUM_RD_PORTS = 2,
    parameter rdw_mode_e   RDW_MODE     = RDW_NEW_DATA,
    localparam int unsigned AW = ($clog2(MEM_DEPTH) > 1) ? $clog2(MEM_DEPTH) : 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               wr_en,
    input  logic [AW-1:0]                      wr_addr,
    input  logic [DATA_WIDTH-1:0]              wr_data,
    output logic                               wr_err,
    input  logic [NUM_RD_PORTS-1:0]            rd_en,
    input  logic [NUM_RD_PORTS*AW-1:0]         rd_addr,
    output logic [NUM_RD_PORTS*DATA_WIDTH-1:0] rd_data,
    output logic [NUM_RD_PORTS-1:0]            rd_valid,
    output logic [NUM_RD_PORTS-1:0]            rd_err
);

    if (DELAY_CYCLES < 1 || NUM_RD_PORTS < 1 || NUM_RD_PORTS > 8 || MEM_DEPTH < 2) begin : g_bad_params
        $error("multiport_delay_mem: illegal parameter combination");
    end

    // Stage 0 is the combinational read at the sampling edge, so one extra register is needed.
    localparam int unsigned PIPE_DEPTH = 32'(DELAY_CYCLES + 1);
    localparam int unsigned PW         = DATA_WIDTH + 1;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic                  wr_ok;

    assign wr_ok = 32'(wr_addr) < MEM_DEPTH;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_err <= 1'b0;
        end else begin
            wr_err <= wr_en && !wr_ok;
            if (wr_en && wr_ok) begin
                mem[wr_addr] <= wr_data;
            end
        end
    end

    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_port
        logic [AW-1:0]         addr;
        logic                  rd_ok;
        logic                  hit;
        logic [DATA_WIDTH-1:0] data;
        logic                  err;
        logic                  out_valid;
        logic [PW-1:0]         out_payload;

        assign addr = rd_addr[p*AW +: AW];

        // Read decode with same-edge write collision resolution.
        always_comb begin
            rd_ok = 32'(addr) < MEM_DEPTH;
            hit   = wr_en && wr_ok && (wr_addr == addr);
            data  = rd_ok ? mem[addr] : '0;
            err   = !rd_ok;
            if (hit) begin
                case (RDW_MODE)
                    RDW_NEW_DATA: data = wr_data;
                    RDW_INVALID: begin
                        data = '0;
                        err  = 1'b1;
                    end
                    default: data = rd_ok ? mem[addr] : '0;
                endcase
            end
        end

        delay_pipe #(
            .WIDTH (PW),
            .DEPTH (PIPE_DEPTH)
        ) u_pipe (
            .clk         (clk),
            .reset       (reset),
            .in_valid    (rd_en[p]),
            .in_payload  ({err, data}),
            .out_valid   (out_valid),
            .out_payload (out_payload)
        );

        assign rd_valid[p]                           = out_valid;
        assign rd_err[p]                             = out_payload[DATA_WIDTH];
        assign rd_data[p*DATA_WIDTH +: DATA_WIDTH]   = out_payload[DATA_WIDTH-1:0];
    end

endmodule

// File: tb/tb_multiport_delay_mem.sv
// Scoreboard bench: three instances (one per collision mode) share stimulus; a monitor checks every output.
module tb_multiport_delay_mem;
    import mem_pkg::*;

    localparam int D = 3;

    typedef struct packed {
        int              due;
        logic [2:0][31:0] d;
        logic [2:0]      e;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [31:0] wr_data;
    logic [1:0]  rd_en;
    logic [5:0]  rd_addr;

    logic        werr [3];
    logic [63:0] rdat [3];
    logic [1:0]  rv   [3];
    logic [1:0]  rerr [3];

    exp_t  q [2][$];
    int    wq[$];
    int    cyc   = 0;
    int    tests = 0;
    int    fails = 0;
    bit    chk_on = 1'b0;
    string mname [3] = '{"old", "new", "inv"};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    multiport_delay_mem #(.MEM_DEPTH(6), .DATA_WIDTH(32), .DELAY_CYCLES(D), .NUM_RD_PORTS(2),
                          .RDW_MODE(RDW_OLD_DATA)) u_old (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_err(werr[0]), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rdat[0]),
        .rd_valid(rv[0]), .rd_err(rerr[0]));

    multiport_delay_mem #(.MEM_DEPTH(6), .DATA_WIDTH(32), .DELAY_CYCLES(D), .NUM_RD_PORTS(2),
                          .RDW_MODE(RDW_NEW_DATA)) u_new (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_err(werr[1]), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rdat[1]),
        .rd_valid(rv[1]), .rd_err(rerr[1]));

    multiport_delay_mem #(.MEM_DEPTH(6), .DATA_WIDTH(32), .DELAY_CYCLES(D), .NUM_RD_PORTS(2),
                          .RDW_MODE(RDW_INVALID)) u_inv (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_err(werr[2]), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rdat[2]),
        .rd_valid(rv[2]), .rd_err(rerr[2]));

    // Monitor: pops expectations when due, otherwise requires an idle (all-zero) port.
    exp_t e;
    bit   ew;
    always @(negedge clk) begin
        if (chk_on) begin
            for (int p = 0; p < 2; p++) begin
                if (q[p].size() != 0 && q[p][0].due == cyc) begin
                    e = q[p].pop_front();
                    for (int m = 0; m < 3; m++) begin
                        tests++;
                        if (!(rv[m][p] === 1'b1 && rdat[m][p*32 +: 32] === e.d[m] && rerr[m][p] === e.e[m])) begin
                            fails++;
                            $display("FAIL rd_p%0d_%s cyc=%0d: got valid=%b data=%h err=%b, want valid=1 data=%h err=%b",
                                     p, mname[m], cyc, rv[m][p], rdat[m][p*32 +: 32], rerr[m][p], e.d[m], e.e[m]);
                        end
                    end
                end else begin
                    for (int m = 0; m < 3; m++) begin
                        tests++;
                        if (!(rv[m][p] === 1'b0 && rdat[m][p*32 +: 32] === 32'h0 && rerr[m][p] === 1'b0)) begin
                            fails++;
                            $display("FAIL idle_p%0d_%s cyc=%0d: got valid=%b data=%h err=%b, want valid=0 data=0 err=0",
                                     p, mname[m], cyc, rv[m][p], rdat[m][p*32 +: 32], rerr[m][p]);
                        end
                    end
                end
            end
            ew = (wq.size() != 0 && wq[0] == cyc);
            if (ew) void'(wq.pop_front());
            for (int m = 0; m < 3; m++) begin
                tests++;
                if (werr[m] !== ew) begin
                    fails++;
                    $display("FAIL wr_err_%s cyc=%0d: got %b, want %b", mname[m], cyc, werr[m], ew);
                end
            end
        end
    end

    task automatic drive(input logic we, input logic [2:0] wa, input logic [31:0] wd,
                         input logic [1:0] ren, input logic [2:0] a0, input logic [2:0] a1);
        wr_en   = we;
        wr_addr = wa;
        wr_data = wd;
        rd_en   = ren;
        rd_addr = {a1, a0};
        if (we && !reset && wa >= 3'd6) wq.push_back(cyc + 1);
    endtask

    task automatic exp_rd(input int p, input logic [31:0] d_old, input logic [31:0] d_new,
                          input logic [31:0] d_inv, input logic e_old, input logic e_new, input logic e_inv);
        exp_t x;
        x.due  = cyc + 1 + D;
        x.d[0] = d_old;
        x.d[1] = d_new;
        x.d[2] = d_inv;
        x.e    = {e_inv, e_new, e_old};
        q[p].push_back(x);
    endtask

    task automatic exp_same(input int p, input logic [31:0] d, input logic er);
        exp_rd(p, d, d, d, er, er, er);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        rd_en   = '0;
        rd_addr = '0;
    endtask

    logic [31:0] vals [6];

    initial begin
        reset   = 1'b1;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        rd_en   = '0;
        rd_addr = '0;
        vals = '{32'h10, 32'h1234, 32'h22, 32'h33, 32'hA5A5_0001, 32'h55AA};

        @(posedge clk);
        #1;
        chk_on = 1'b1;
        tick();
        reset = 1'b0;

        // Read of a freshly reset word on port 0 only.
        drive(1'b0, 3'd0, 32'h0, 2'b01, 3'd2, 3'd0);
        exp_same(0, 32'h0, 1'b0);
        tick();

        // Write then dual-port read of the same word.
        drive(1'b1, 3'd4, 32'hA5A5_0001, 2'b00, 3'd0, 3'd0);
        tick();
        drive(1'b0, 3'd0, 32'h0, 2'b11, 3'd4, 3'd4);
        exp_same(0, 32'hA5A5_0001, 1'b0);
        exp_same(1, 32'hA5A5_0001, 1'b0);
        tick();

        // Same-edge write/read collision on port 0; port 1 reads elsewhere.
        drive(1'b1, 3'd1, 32'h55, 2'b00, 3'd0, 3'd0);
        tick();
        drive(1'b1, 3'd1, 32'h1234, 2'b11, 3'd1, 3'd3);
        exp_rd(0, 32'h55, 32'h1234, 32'h0, 1'b0, 1'b0, 1'b1);
        exp_same(1, 32'h0, 1'b0);
        tick();
        drive(1'b0, 3'd0, 32'h0, 2'b01, 3'd1, 3'd0);
        exp_same(0, 32'h1234, 1'b0);
        tick();

        // Out-of-range write and reads.
        drive(1'b1, 3'd7, 32'hDEAD_BEEF, 2'b00, 3'd0, 3'd0);
        tick();
        drive(1'b0, 3'd0, 32'h0, 2'b11, 3'd6, 3'd7);
        exp_same(0, 32'h0, 1'b1);
        exp_same(1, 32'h0, 1'b1);
        tick();

        drive(1'b1, 3'd0, 32'h10, 2'b00, 3'd0, 3'd0); tick();
        drive(1'b1, 3'd2, 32'h22, 2'b00, 3'd0, 3'd0); tick();
        drive(1'b1, 3'd3, 32'h33, 2'b00, 3'd0, 3'd0); tick();
        drive(1'b1, 3'd5, 32'h55AA, 2'b00, 3'd0, 3'd0); tick();

        // Back-to-back reads of every word on port 1.
        for (int a = 0; a < 6; a++) begin
            drive(1'b0, 3'd0, 32'h0, 2'b10, 3'd0, 3'(a));
            exp_same(1, vals[a], 1'b0);
            tick();
        end
        repeat (6) tick();

        // Reads in flight are killed by reset; requests during reset are ignored.
        drive(1'b0, 3'd0, 32'h0, 2'b11, 3'd0, 3'd5);
        tick();
        drive(1'b0, 3'd0, 32'h0, 2'b01, 3'd3, 3'd0);
        tick();
        reset = 1'b1;
        drive(1'b1, 3'd3, 32'hFFFF, 2'b11, 3'd3, 3'd3);
        tick();
        reset = 1'b0;
        repeat (6) tick();

        for (int a = 0; a < 6; a++) begin
            drive(1'b0, 3'd0, 32'h0, 2'b11, 3'(a), 3'(5 - a));
            exp_same(0, 32'h0, 1'b0);
            exp_same(1, 32'h0, 1'b0);
            tick();
        end

        for (int i = 0; i < 20 && (q[0].size() != 0 || q[1].size() != 0 || wq.size() != 0); i++) tick();
        tick();
        tests++;
        if (q[0].size() != 0 || q[1].size() != 0 || wq.size() != 0) begin
            fails++;
            $display("FAIL drain: got pending p0=%0d p1=%0d wr=%0d, want all 0", q[0].size(), q[1].size(), wq.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/multiport_delay_mem.md
MULTIPORT_DELAY_MEM -- requirements
Module: multiport_delay_mem

Interface
REQ-001 Parameter MEM_DEPTH, default 8, number of words; any value >= 2, not required to be a power of two.
REQ-002 Parameter DATA_WIDTH, default 32, bits per word.
REQ-003 Parameter DELAY_CYCLES, default 3, read latency in clock edges; legal range >= 1.
REQ-004 Parameter NUM_RD_PORTS, default 2, independent read ports; legal range 1..8.
REQ-005 Parameter RDW_MODE, default RDW_NEW_DATA, same-cycle read/write collision policy (RDW_OLD_DATA, RDW_NEW_DATA, RDW_INVALID).
REQ-006 Localparam AW = max(1, $clog2(MEM_DEPTH)).
REQ-007 clk  input  1  clock; all state updates on rising edge.
REQ-008 reset  input  1  synchronous, active-high reset.
REQ-009 wr_en  input  1  write request, sampled each edge.
REQ-010 wr_addr  input  AW  write word address.
REQ-011 wr_data  input  DATA_WIDTH  write data.
REQ-012 wr_err  output  1  one-cycle pulse: previous-edge write address out of range.
REQ-013 rd_en  input  NUM_RD_PORTS  per-port read request.
REQ-014 rd_addr  input  NUM_RD_PORTS x AW  per-port read address.
REQ-015 rd_data  output  NUM_RD_PORTS x DATA_WIDTH  per-port read data.
REQ-016 rd_valid  output  NUM_RD_PORTS  per-port read-data qualifier.
REQ-017 rd_err  output  NUM_RD_PORTS  per-port error flag, meaningful only with rd_valid.

Function
REQ-018 Write: wr_en=1 and wr_addr<MEM_DEPTH at edge T SHALL update mem[wr_addr] at T; wr_addr>=MEM_DEPTH SHALL leave memory unchanged and set wr_err=1 for the cycle after T.
REQ-019 Read: rd_en[p]=1 at edge T SHALL produce rd_valid[p]=1 with its data exactly after edge T+DELAY_CYCLES, for one cycle; rd_en[p]=0 at T yields rd_valid[p]=0 then.
REQ-020 Pipelining: each port SHALL accept one read per cycle with no stalls; results return in issue order.
REQ-021 Read value is mem[rd_addr] as sampled at edge T, before any write at T, except on collision per REQ-022.
REQ-022 Collision (wr_en, in-range wr_addr==rd_addr[p], same edge): OLD_DATA returns pre-write word; NEW_DATA returns wr_data; INVALID returns zero with rd_err[p]=1.
REQ-023 Read with rd_addr[p]>=MEM_DEPTH SHALL return zero data with rd_err[p]=1 and rd_valid[p]=1 at the normal latency.
REQ-024 Multiple ports reading the same address in one cycle SHALL all receive the identical word.
REQ-025 Whenever rd_valid[p]=0, rd_data[p] SHALL be all-zero and rd_err[p]=0; no X on any output outside reset.
REQ-026 Ports are independent; activity on one port SHALL not alter timing or data of another.

Reset
REQ-027 While reset=1 at an edge: every memory word cleared to 0; all pipeline stages invalidated; rd_valid, rd_err, rd_data, wr_err cleared to 0 after that edge.
REQ-028 Reads in flight when reset asserts SHALL be discarded, never emerging after reset deasserts.
REQ-029 wr_en and rd_en SHALL be ignored during reset; first accepted request is at the first edge with reset=0.

Structure
REQ-030 Shared package mem_pkg SHALL hold typedef enum rdw_mode_e {RDW_OLD_DATA, RDW_NEW_DATA, RDW_INVALID}.
REQ-031 Sub-module delay_pipe (params WIDTH, DEPTH; clk, reset, in_valid, in_payload -> out_valid, out_payload) SHALL implement the per-port latency line, one instance per read port, payload = {err, data}.
REQ-032 Memory array SHALL be flip-flops; stage-0 read decode and collision logic combinational, all remaining latency in delay_pipe.
REQ-033 Elaboration-time check SHALL reject DELAY_CYCLES<1 or NUM_RD_PORTS outside 1..8.

Verification (MEM_DEPTH=6, DATA_WIDTH=32, DELAY_CYCLES=3, NUM_RD_PORTS=2)
REQ-034 Reset then read port0 addr 2 -> rd_valid[0]=1, rd_data[0]=0x0 exactly 3 edges later; port1 rd_valid=0, data 0.
REQ-035 Write 0xA5A5_0001 to addr 4, next cycle read addr 4 on both ports -> both return 0xA5A5_0001 3 edges later, same cycle.
REQ-036 Same edge write 0x1234 to addr 1 (prior 0x55) and port0 read addr 1, each RDW_MODE -> OLD 0x55, NEW 0x1234, INVALID 0 with rd_err[0]=1.
REQ-037 Write addr 7 -> wr_err pulse one cycle, memory unchanged; read addr 6 -> rd_valid=1, rd_err=1, data 0.
REQ-038 Back-to-back reads addr 0..5 on port1, six consecutive cycles -> six consecutive rd_valid cycles, data in order, no gaps.
REQ-039 Issue reads on 2 consecutive cycles, assert reset the following cycle for 1 cycle -> no rd_valid ever appears; memory reads back 0.
